uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the system's single UART transmitter among NUM_REQ byte requesters, for example the CPU memory-mapped TX port, a debug/echo path and a status reporter.
- Round-robin arbitration. One byte is accepted into a holding register, then handed to the transmitter with a start/ready handshake.
- Sits between the requesters and the UART TX serializer that drives TxD.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width per requester
- ID_W, 2, width of grant_id; must equal clog2(NUM_REQ)

Ports:
- osc_clk  input  1  system clock; all logic on rising edge
- clr  input  1  synchronous active-high reset
- req_valid  input  NUM_REQ  per-requester byte available
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W]
- req_lock  input  NUM_REQ  per-requester grant-hold request (used only with the optional feature)
- req_ready  output  NUM_REQ  one-hot accept strobe; the byte is taken at this edge
- tx_data  output  DATA_W  byte to the transmitter
- tx_start  output  1  transmit request; held until accepted
- tx_ready  input  1  transmitter idle; a transfer is accepted on the cycle where tx_start && tx_ready
- grant_id  output  ID_W  index of the requester that owns the held byte
- arb_busy  output  1  high while in SEND

Behaviour:
- Reset (clr high at an edge):
  - state=IDLE; tx_start=0; tx_data=0; grant_id=0; arb_busy=0; req_ready=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-SEND discards the held byte. No tx_start is issued afterwards.
- States: IDLE, SEND.
- IDLE:
  - If req_valid==0, stay in IDLE.
  - Otherwise select g = the first set bit of req_valid, searching circularly from last_grant+1 (mod NUM_REQ).
  - req_ready[g]=1 combinationally in this cycle; all other req_ready bits are 0.
  - At the edge: hold<=req_data[g]; grant_id<=g; last_grant<=g; state<=SEND.
- SEND:
  - tx_start=1, tx_data=hold, arb_busy=1, req_ready=0.
  - If tx_ready is high, the transfer completes at this edge and state goes to IDLE.
  - Otherwise stay in SEND with outputs stable.
- Throughput: at least 2 cycles per byte (IDLE accept plus SEND handoff). The next byte can be accepted while the serializer is shifting, which gives one byte of buffering.
- Requester rule: req_valid and req_data stay stable until req_ready. Dropping valid before ready is allowed; that requester simply loses the arbitration.
- Simultaneous requests: exactly one grant per IDLE cycle. Round-robin fairness holds: with all requesters continuously valid, the grant order is 0,1,2,3,0,...
- Wrap-around: search index computed mod NUM_REQ. With last_grant=NUM_REQ-1, the search starts at 0.
- Single requester: always granted, with no idle gap beyond the IDLE cycle.
- tx_ready high throughout SEND: handoff takes 1 cycle.
- tx_ready low throughout SEND: the arbiter waits indefinitely. There is no timeout.
- Outputs tx_start, tx_data, grant_id and arb_busy are registered or state-decoded. req_ready is the only combinational output (it depends on req_valid).

Optional Feature:
- Macro: UART_TX_ARB_LOCK_EN.
- Defined:
  - If req_lock[g] is high at the accept edge, the arbiter sets locked=1 and owner=g.
  - While locked, only owner is eligible in IDLE. Other requesters are not granted even if owner's valid is low; the arbiter idles.
  - locked clears on any IDLE cycle where req_lock[owner]=0. Normal round-robin resumes from owner+1 in that same cycle.
  - Purpose: multi-byte messages are not interleaved.
  - clr clears locked.
- Not defined: req_lock is ignored, no lock state is synthesized, and the arbiter is pure round-robin.

Decomposition:
- Package uart_arb_pkg holds:
  - state encoding constants IDLE=1'b0, SEND=1'b1
  - default NUM_REQ and DATA_W
  - a clog2 constant function for ID_W
- Sub-module rr_pick:
  - Combinational circular-priority picker.
  - Inputs: req vector and last_grant. Outputs: one-hot grant, encoded index, any flag.
  - Reusable by a future memory-port arbiter.

Test Plan:
- Reset: hold clr high 3 cycles during SEND -> tx_start=0, req_ready=0, grant_id=0; the next grant with all valid goes to requester 0.
- Single byte: req_valid=4'b0100, byte 8'h41, tx_ready=1 -> req_ready=4'b0100 in cycle 1; tx_start=1 with tx_data=8'h41 and grant_id=2 in cycle 2; IDLE in cycle 3.
- Fairness: all 4 valid continuously with bytes 8'hA0..8'hA3, tx_ready=1 -> the tx_data sequence is A0,A1,A2,A3,A0,...; each requester receives 1/4 of the grants over 40 bytes.
- Backpressure: tx_ready=0 for 20 cycles during SEND -> tx_start and tx_data stay stable, req_ready stays 0 throughout; tx_ready=1 -> one transfer, then IDLE.
- Wrap and sparse: last_grant=3, req_valid=4'b1010 -> requester 1 is granted, then 3, then 1.
- Lock (UART_TX_ARB_LOCK_EN):
  - Setup: requester 1 sends 3 bytes with lock high while requester 0 and requester 2 stay valid.
  - Required: tx_data carries requester 1's bytes only until its lock drops.
  - Required after release: the next grant goes to requester 2.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared state encoding, default sizing and width helper for the UART TX arbiter.
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular-priority picker: first set bit of req after last, wrapping mod N.
// Latency: purely combinational. Backpressure: none; the caller decides whether the grant is used.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        any   = |req;
        // Walk from farthest to nearest so the nearest set bit after last is the final write.
        for (int k = N; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % N);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX serializer among NUM_REQ byte sources; UART_TX_ARB_LOCK_EN adds grant locking.
// Latency: byte accepted in IDLE, offered on tx_start the next cycle; at least 2 cycles per byte.
// Backpressure: tx_start/tx_data held until tx_ready; req_ready stays low while a byte is held.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic                      osc_clk,
    input  logic                      clr,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_ready,
    output logic [ID_W-1:0]           grant_id,
    output logic                      arb_busy
);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [DATA_W-1:0]  hold;
    logic [ID_W-1:0]    grant_q;
    logic [ID_W-1:0]    last_grant;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic [DATA_W-1:0]  pick_data;
    logic               accept;

`ifdef UART_TX_ARB_LOCK_EN
    logic               locked;
    logic [ID_W-1:0]    owner;
    logic               lock_live;

    // While the owner still asserts its lock nobody else is eligible, even if the owner is idle.
    assign lock_live = locked && req_lock[owner];
    assign eligible  = lock_live ? (req_valid & (NUM_REQ'(1) << owner)) : req_valid;

    always_ff @(posedge osc_clk) begin
        if (clr) begin
            locked <= 1'b0;
            owner  <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                locked <= req_lock[pick_idx];
                owner  <= pick_idx;
            end else if (!req_lock[owner]) begin
                locked <= 1'b0;
            end
        end
    end
`else
    logic unused_lock;

    assign unused_lock = ^req_lock;
    assign eligible    = req_valid;
`endif

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req   (eligible),
        .last  (last_grant),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign accept = (state == IDLE) && pick_any && !clr;

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) pick_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge osc_clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SEND;
                    req_ready = pick_grant;
                end
            end
            SEND: begin
                if (tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // last_grant resets to the top index so requester 0 wins the first search.
    always_ff @(posedge osc_clk) begin
        if (clr) begin
            hold       <= '0;
            grant_q    <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            hold       <= pick_data;
            grant_q    <= pick_idx;
            last_grant <= pick_idx;
        end
    end

    assign tx_start = (state == SEND);
    assign arb_busy = (state == SEND);
    assign tx_data  = hold;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter; the lock scenario runs only when UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
    } exp_t;

    logic            osc_clk = 1'b0;
    logic            clr;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_lock;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   tx_data;
    logic            tx_start;
    logic            tx_ready;
    logic [IW-1:0]   grant_id;
    logic            arb_busy;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 osc_clk = ~osc_clk;

    uart_tx_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .ID_W    (IW)
    ) dut (
        .osc_clk   (osc_clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy)
    );

    task automatic next_cycle();
        @(posedge osc_clk);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [DW-1:0] b);
        req_data[i*DW +: DW] = b;
    endtask

    task automatic test_reset();
        exp_t e;
        clr = 1'b1; req_valid = '0; req_lock = '0; req_data = '0; tx_ready = 1'b0;
        repeat (2) next_cycle();
        @(negedge osc_clk);
        n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        n_cmp++; if (arb_busy !== 1'b0) begin n_bad++; $display("FAIL reset_arb_busy got %b want 0", arb_busy); end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        // Enter SEND with a byte that the following reset must discard.
        clr = 1'b0; set_byte(0, 8'h11); req_valid = 4'b0001;
        next_cycle();
        req_valid = '0;
        @(negedge osc_clk);
        n_cmp++; if (tx_start !== 1'b1) begin n_bad++; $display("FAIL pre_reset_send got %b want 1", tx_start); end
        clr = 1'b1; req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_byte(i, 8'(8'h20 + i));
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge osc_clk);
            n_cmp++;
            if (tx_start !== 1'b0 || req_ready !== 4'b0000 || grant_id !== 2'd0 || tx_data !== 8'h00) begin
                n_bad++;
                $display("FAIL clr_mid_send cycle %0d got start=%b ready=%b id=%0d data=%h want 0/0000/0/00",
                         c, tx_start, req_ready, grant_id, tx_data);
            end
        end
        clr = 1'b0; tx_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL first_grant_after_reset got %b want 0001", req_ready); end
        sb.push_back(exp_t'{data: 8'h20, id: 2'd0});
        next_cycle();
        req_valid = '0;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            @(negedge osc_clk);
            if (tx_start && tx_ready) begin
                e = sb.pop_front();
                n_cmp++;
                if (tx_data !== e.data || grant_id !== e.id) begin
                    n_bad++;
                    $display("FAIL reset_xfer got %h/id%0d want %h/id%0d", tx_data, grant_id, e.data, e.id);
                end
            end
            next_cycle();
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL reset_drain got %0d pending want 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_single();
        exp_t e;
        tx_ready = 1'b1; req_valid = 4'b0100; set_byte(2, 8'h41);
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_req_ready got %b want 0100", req_ready); end
        sb.push_back(exp_t'{data: 8'h41, id: 2'd2});
        next_cycle();
        req_valid = '0;
        @(negedge osc_clk);
        n_cmp++; if (tx_start !== 1'b1) begin n_bad++; $display("FAIL single_tx_start got %b want 1", tx_start); end
        n_cmp++; if (arb_busy !== 1'b1) begin n_bad++; $display("FAIL single_arb_busy got %b want 1", arb_busy); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL single_ready_in_send got %b want 0000", req_ready); end
        n_cmp++;
        if (!(tx_start && tx_ready) || sb.size() == 0) begin
            n_bad++; $display("FAIL single_xfer got no transfer want one");
        end else begin
            e = sb.pop_front();
            if (tx_data !== e.data || grant_id !== e.id) begin
                n_bad++;
                $display("FAIL single_xfer got %h/id%0d want %h/id%0d", tx_data, grant_id, e.data, e.id);
            end
        end
        next_cycle();
        @(negedge osc_clk);
        n_cmp++; if (tx_start !== 1'b0 || arb_busy !== 1'b0) begin n_bad++; $display("FAIL single_back_idle got start=%b busy=%b want 0/0", tx_start, arb_busy); end
        sb.delete();
    endtask

    task automatic test_fairness();
        exp_t e;
        int   pops;
        int   cycles;
        int   cnt[N];
        clr = 1'b1; req_valid = '0;
        next_cycle();
        clr = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < N; i++) begin set_byte(i, 8'(8'hA0 + i)); cnt[i] = 0; end
        for (int k = 0; k < 40; k++) sb.push_back(exp_t'{data: 8'(8'hA0 + k % 4), id: 2'(k % 4)});
        req_valid = 4'b1111;
        pops = 0; cycles = 0;
        while (pops < 40 && cycles < 200) begin
            @(negedge osc_clk);
            cycles++;
            if (tx_start && tx_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL fair_unexpected got %h/id%0d want nothing", tx_data, grant_id);
                end else begin
                    e = sb.pop_front();
                    if (tx_data !== e.data || grant_id !== e.id) begin
                        n_bad++;
                        $display("FAIL fair_xfer %0d got %h/id%0d want %h/id%0d", pops, tx_data, grant_id, e.data, e.id);
                    end
                end
                cnt[grant_id]++;
                pops++;
                if (pops == 40) req_valid = '0;
            end
            next_cycle();
        end
        n_cmp++; if (cycles != 80) begin n_bad++; $display("FAIL fair_throughput got %0d cycles want 80", cycles); end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (cnt[i] != 10) begin n_bad++; $display("FAIL fair_share req%0d got %0d want 10", i, cnt[i]); end
        end
        sb.delete();
    endtask

    task automatic test_backpressure();
        exp_t e;
        tx_ready = 1'b0; set_byte(0, 8'h5A); req_valid = 4'b0001;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_accept got %b want 0001", req_ready); end
        sb.push_back(exp_t'{data: 8'h5A, id: 2'd0});
        sb.push_back(exp_t'{data: 8'h5B, id: 2'd0});
        next_cycle();
        set_byte(0, 8'h5B);
        for (int c = 0; c < 20; c++) begin
            @(negedge osc_clk);
            n_cmp++;
            if (tx_start !== 1'b1 || tx_data !== 8'h5A || req_ready !== 4'b0000 || arb_busy !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d got start=%b data=%h ready=%b want 1/5a/0000", c, tx_start, tx_data, req_ready);
            end
            next_cycle();
        end
        tx_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(negedge osc_clk);
            n_cmp++;
            if (!(tx_start && tx_ready)) begin
                n_bad++; $display("FAIL bp_xfer %0d got no transfer want one", b);
            end else begin
                e = sb.pop_front();
                if (tx_data !== e.data || grant_id !== e.id) begin
                    n_bad++; $display("FAIL bp_xfer %0d got %h/id%0d want %h/id%0d", b, tx_data, grant_id, e.data, e.id);
                end
            end
            next_cycle();
            @(negedge osc_clk);
            n_cmp++;
            if (arb_busy !== 1'b0 || req_ready !== ((b == 0) ? 4'b0001 : 4'b0000)) begin
                n_bad++; $display("FAIL bp_idle %0d got busy=%b ready=%b", b, arb_busy, req_ready);
            end
            next_cycle();
            req_valid = '0;
        end
        sb.delete();
    endtask

    task automatic test_wrap();
        exp_t e;
        int   pops;
        int   cycles;
        tx_ready = 1'b1; set_byte(3, 8'hC3); req_valid = 4'b1000;
        sb.push_back(exp_t'{data: 8'hC3, id: 2'd3});
        sb.push_back(exp_t'{data: 8'hB1, id: 2'd1});
        sb.push_back(exp_t'{data: 8'hB3, id: 2'd3});
        sb.push_back(exp_t'{data: 8'hB1, id: 2'd1});
        pops = 0; cycles = 0;
        while (pops < 4 && cycles < 40) begin
            @(negedge osc_clk);
            cycles++;
            if (tx_start && tx_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL wrap_unexpected got %h/id%0d want nothing", tx_data, grant_id);
                end else begin
                    e = sb.pop_front();
                    if (tx_data !== e.data || grant_id !== e.id) begin
                        n_bad++; $display("FAIL wrap_xfer %0d got %h/id%0d want %h/id%0d", pops, tx_data, grant_id, e.data, e.id);
                    end
                end
                pops++;
                if (pops == 1) begin set_byte(1, 8'hB1); set_byte(3, 8'hB3); req_valid = 4'b1010; end
                if (pops == 4) req_valid = '0;
            end
            next_cycle();
        end
        n_cmp++; if (pops != 4) begin n_bad++; $display("FAIL wrap_count got %0d want 4", pops); end
        sb.delete();
    endtask

`ifdef UART_TX_ARB_LOCK_EN
    task automatic test_lock();
        exp_t         e;
        int           pops;
        int           cycles;
        int           sent1;
        logic [N-1:0] rr;
        clr = 1'b1; req_valid = '0; req_lock = '0;
        next_cycle();
        clr = 1'b0; tx_ready = 1'b1;
        set_byte(0, 8'hE0); set_byte(1, 8'hD0); set_byte(2, 8'hF2); req_valid = 4'b0001;
        sb.push_back(exp_t'{data: 8'hE0, id: 2'd0});
        sb.push_back(exp_t'{data: 8'hD0, id: 2'd1});
        sb.push_back(exp_t'{data: 8'hD1, id: 2'd1});
        sb.push_back(exp_t'{data: 8'hD2, id: 2'd1});
        sb.push_back(exp_t'{data: 8'hF2, id: 2'd2});
        pops = 0; cycles = 0; sent1 = 0;
        while (pops < 5 && cycles < 60) begin
            @(negedge osc_clk);
            cycles++;
            rr = req_ready;
            if (tx_start && tx_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL lock_unexpected got %h/id%0d want nothing", tx_data, grant_id);
                end else begin
                    e = sb.pop_front();
                    if (tx_data !== e.data || grant_id !== e.id) begin
                        n_bad++; $display("FAIL lock_xfer %0d got %h/id%0d want %h/id%0d", pops, tx_data, grant_id, e.data, e.id);
                    end
                end
                pops++;
                if (pops == 1) begin req_valid = 4'b0111; req_lock = 4'b0010; end
                if (pops == 5) req_valid = '0;
            end
            next_cycle();
            if (rr[1]) begin
                sent1++;
                if (sent1 < 3) set_byte(1, 8'(8'hD0 + sent1));
                else begin req_valid[1] = 1'b0; req_lock[1] = 1'b0; end
            end
        end
        n_cmp++; if (pops != 5) begin n_bad++; $display("FAIL lock_count got %0d want 5", pops); end
        sb.delete();
    endtask
`endif

    initial begin
        clr = 1'b1; req_valid = '0; req_lock = '0; req_data = '0; tx_ready = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
`ifdef UART_TX_ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
